// File: rtl/bcd_to_bin_converter.sv
`default_nettype none
// ============================================================================
// Module   : bcd_to_bin_converter
// Purpose  : Sequential signed-BCD to two's-complement converter, one digit
//            per cycle MSD first. Optional macro BCD_TO_BIN_SAT_EN selects
//            saturation on overflow (default build wraps).
// Revision : 1.0 - initial release
// ============================================================================
module bcd_to_bin_converter #(
    parameter int DIGITS    = 4,
    parameter int OUT_WIDTH = 20
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DIGITS*4-1:0]   bcd_in,
    input  logic                  sign_in,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [OUT_WIDTH-1:0]  bin_out,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  err,
    output logic                  ovf
);

    localparam int ACC_W = ((OUT_WIDTH > 4*DIGITS) ? OUT_WIDTH : 4*DIGITS) + 1;
    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    localparam logic [IDX_W-1:0] c_idx_last = IDX_W'(DIGITS - 1);
    localparam logic [ACC_W-1:0] c_pos_max  =
        {{(ACC_W-OUT_WIDTH+1){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
    localparam logic [ACC_W-1:0] c_neg_max  = c_pos_max + ACC_W'(1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CONV = 2'd1;
    localparam logic [1:0] S_NEG  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    logic [1:0]           r_state;
    logic [1:0]           w_state_nxt;
    logic [DIGITS*4-1:0]  r_bcd;
    logic                 r_sign;
    logic [ACC_W-1:0]     r_acc;
    logic [IDX_W-1:0]     r_idx;
    logic                 r_err;
    logic                 r_ovf;
    logic [OUT_WIDTH-1:0] r_bin;

    logic [3:0]           w_digit;
    logic [ACC_W-1:0]     w_acc_next;
    logic                 w_ovf;
    logic [OUT_WIDTH-1:0] w_wrap;
    logic [OUT_WIDTH-1:0] w_bin;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (in_valid)        w_state_nxt = S_CONV;
            S_CONV:  if (r_idx == '0)     w_state_nxt = S_NEG;
            S_NEG:                        w_state_nxt = S_DONE;
            S_DONE:  if (out_ready)       w_state_nxt = S_IDLE;
            default:                      w_state_nxt = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Output decode
    // ------------------------------------------------------------------
    always_comb begin
        in_ready  = (r_state == S_IDLE);
        out_valid = (r_state == S_DONE);
    end

    assign bin_out = r_bin;
    assign err     = r_err;
    assign ovf     = r_ovf;

    // ------------------------------------------------------------------
    // Datapath
    // ------------------------------------------------------------------
    always_comb begin
        w_digit = 4'd0;
        for (int i = 0; i < DIGITS; i++) begin
            if (r_idx == IDX_W'(i)) begin
                w_digit = r_bcd[i*4 +: 4];
            end
        end
    end

    // acc*10 as shifts; the accumulator is wide enough that even 4'hF digits never overflow
    assign w_acc_next = (r_acc << 3) + (r_acc << 1) + ACC_W'(w_digit);

    assign w_ovf = r_sign ? (r_acc > c_neg_max) : (r_acc > c_pos_max);

    // Low bits of a negation depend only on low bits of the operand
    assign w_wrap = r_sign ? (OUT_WIDTH'(0) - r_acc[OUT_WIDTH-1:0])
                           : r_acc[OUT_WIDTH-1:0];

`ifdef BCD_TO_BIN_SAT_EN
    localparam logic [OUT_WIDTH-1:0] c_sat_pos = {1'b0, {(OUT_WIDTH-1){1'b1}}};
    localparam logic [OUT_WIDTH-1:0] c_sat_neg = {1'b1, {(OUT_WIDTH-1){1'b0}}};

    assign w_bin = w_ovf ? (r_sign ? c_sat_neg : c_sat_pos) : w_wrap;
`else
    assign w_bin = w_wrap;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_bcd  <= '0;
            r_sign <= 1'b0;
            r_acc  <= '0;
            r_idx  <= '0;
            r_err  <= 1'b0;
            r_ovf  <= 1'b0;
            r_bin  <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_bcd  <= bcd_in;
                        r_sign <= sign_in;
                        r_acc  <= '0;
                        r_err  <= 1'b0;
                        r_ovf  <= 1'b0;
                        r_idx  <= c_idx_last;
                    end
                end
                S_CONV: begin
                    r_acc <= w_acc_next;
                    if (w_digit > 4'd9) begin
                        r_err <= 1'b1;
                    end
                    r_idx <= r_idx - IDX_W'(1);
                end
                S_NEG: begin
                    r_ovf <= w_ovf;
                    r_bin <= w_bin;
                end
                default: begin
                end
            endcase
        end
    end

endmodule
`default_nettype wire
